// File: rtl/mult_iter_if.sv
// Handshake and data bundle between the execute stage and the iterative
// multiplier. The pipeline side is the master; the multiplier is the slave.
interface mult_iter_if #(
  parameter int WIDTH = 32
);

  logic                 start;
  logic                 is_signed;
  logic                 flush;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   z;

  modport master (
    output start,
    output is_signed,
    output flush,
    output a,
    output b,
    input  busy,
    input  done,
    input  z
  );

  modport slave (
    input  start,
    input  is_signed,
    input  flush,
    input  a,
    input  b,
    output busy,
    output done,
    output z
  );

endinterface

// File: rtl/mult_iter.sv
// Iterative shift-add multiplier for MULT/MULTU.
// Operands are reduced to magnitudes when signed, multiplied STEP bits per
// cycle into a 2*WIDTH accumulator, then sign-corrected in a final FIX cycle.
// Latency is fixed: no early exit on zero operands, so the pipeline stall
// length never depends on data.
// WIDTH must be >= 2 and STEP must divide WIDTH.
module mult_iter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic        clk,
  input  logic        reset,
  mult_iter_if.slave  bus
);

  localparam int NSTEPS = WIDTH / STEP;
  localparam int CW     = $clog2(NSTEPS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 neg_q, neg_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   z_q, z_d;

  logic [WIDTH-1:0]     magA;
  logic [WIDTH-1:0]     magB;
  logic [2*WIDTH-1:0]   pp;

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1), which
  // still fits as an unsigned WIDTH-bit number.
  always_comb begin
    magA = bus.a;
    magB = bus.b;
    if (bus.is_signed && bus.a[WIDTH-1]) begin
      magA = -bus.a;
    end
    if (bus.is_signed && bus.b[WIDTH-1]) begin
      magB = -bus.b;
    end
  end

  // Partial product of the shifted multiplicand and the low STEP multiplier bits.
  always_comb begin
    pp = '0;
    for (int i = 0; i < STEP; i++) begin
      if (mplier_q[i]) begin
        pp = pp + (mcand_q << i);
      end
    end
  end

  // Next-state logic: accept in IDLE, accumulate in CALC, publish in FIX.
  // Flush in CALC/FIX abandons the operation without touching z.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    neg_d    = neg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    z_d      = z_q;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          mcand_d  = {{WIDTH{1'b0}}, magA};
          mplier_d = magB;
          acc_d    = '0;
          count_d  = CW'(NSTEPS);
          neg_d    = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          busy_d   = 1'b1;
          state_d  = CALC;
        end
      end

      CALC: begin
        if (bus.flush) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          acc_d    = acc_q + pp;
          mcand_d  = mcand_q << STEP;
          mplier_d = mplier_q >> STEP;
          count_d  = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_d = FIX;
          end
        end
      end

      FIX: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (!bus.flush) begin
          z_d    = neg_q ? -acc_q : acc_q;
          done_d = 1'b1;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear of everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      z_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      z_q      <= z_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.z    = z_q;

endmodule
